// File: rtl/pwm_medidor_if.sv
// pwm_medidor_if: PWM input line and measurement report bundle.
// The measuring block sits on the slave side; whoever drives the line
// and consumes the reports uses the master side.
interface pwm_medidor_if #(
    parameter int R  = 6,
    parameter int CW = 16
) ();
    logic          pwm_in;
    logic [CW-1:0] alto;
    logic [CW-1:0] periodo;
    logic [R-1:0]  duty;
    logic          valid;
    logic          stuck;
    logic          overrun;

    modport master (
        output pwm_in,
        input  alto,
        input  periodo,
        input  duty,
        input  valid,
        input  stuck,
        input  overrun
    );

    modport slave (
        input  pwm_in,
        output alto,
        output periodo,
        output duty,
        output valid,
        output stuck,
        output overrun
    );
endinterface

// File: rtl/pwm_medidor.sv
// pwm_medidor: measures an asynchronous PWM line in clk cycles.
// Reports high time, period and duty = floor(alto * 2^R / periodo), and flags
// a line stuck at a constant level when the cycle counter saturates.
module pwm_medidor #(
    parameter int R  = 6,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         rst,
    pwm_medidor_if.slave bus
);
    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [R-1:0]   DUTY_MAX  = '1;
    localparam int             DCW       = $clog2(R + 1);
    localparam logic [DCW-1:0] DIV_STEPS = DCW'(R);

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        ALTO   = 2'd1,
        BAJO   = 2'd2
    } state_t;

    // input path
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       edge_q, edge_d;
    logic [1:0] settle_q, settle_d;
    logic       rise, fall, any_edge, level, level_ok;

    // cycle counter
    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_max;

    // FSM
    state_t        state_q, state_d;
    logic          seen_low_q, seen_low_d;
    logic          reported_q, reported_d;
    logic [CW-1:0] h_q, h_d;
    logic          capture, tout_hi, tout_lo;

    // divider
    logic           busy_q, busy_d;
    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic [R-1:0]   quo_q, quo_d;
    logic [CW-1:0]  dh_q, dh_d;
    logic [CW-1:0]  dp_q, dp_d;
    logic [CW:0]    rem_sh;

    // report registers
    logic [CW-1:0] alto_q, alto_d;
    logic [CW-1:0] periodo_q, periodo_d;
    logic [R-1:0]  duty_q, duty_d;
    logic          valid_q, valid_d;
    logic          stuck_q, stuck_d;
    logic          overrun_q, overrun_d;

    // Synchroniser next values; settle counts the two post-reset shifts so the
    // zeros loaded by reset are never mistaken for a genuine low level.
    always_comb begin
        sync1_d  = bus.pwm_in;
        sync2_d  = sync1_q;
        edge_d   = sync2_q;
        settle_d = settle_q;
        if (settle_q != 2'd2) begin
            settle_d = settle_q + 2'd1;
        end
    end

    // Two-flop synchroniser, edge-detect register and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            settle_q <= settle_d;
        end
    end

    assign level    = sync2_q;
    assign level_ok = (settle_q == 2'd2);
    assign rise     = sync2_q & ~edge_q;
    assign fall     = ~sync2_q & edge_q;
    assign any_edge = rise | fall;

    // Cycle counter: a rise restarts it at 1, otherwise it counts up and saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = {{(CW-1){1'b0}}, 1'b1};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign at_max = (cnt_q == CNT_MAX);

    // Cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // FSM state register with its side flags and the latched high time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ESPERA;
            seen_low_q <= 1'b0;
            reported_q <= 1'b0;
            h_q        <= '0;
        end else begin
            state_q    <= state_d;
            seen_low_q <= seen_low_d;
            reported_q <= reported_d;
            h_q        <= h_d;
        end
    end

    // Next-state logic; edge strobes take priority over a saturated counter.
    // reported blocks a second timeout until a new measurement starts.
    always_comb begin
        state_d    = state_q;
        seen_low_d = seen_low_q;
        reported_d = reported_q;
        h_d        = h_q;
        capture    = 1'b0;
        tout_hi    = 1'b0;
        tout_lo    = 1'b0;
        unique case (state_q)
            ESPERA: begin
                if (level_ok && !level) begin
                    seen_low_d = 1'b1;
                end
                if (rise && seen_low_q) begin
                    state_d    = ALTO;
                    reported_d = 1'b0;
                end else if (!any_edge && at_max && !reported_q) begin
                    reported_d = 1'b1;
                    if (level) begin
                        tout_hi    = 1'b1;
                        seen_low_d = 1'b0;
                    end else begin
                        tout_lo    = 1'b1;
                        seen_low_d = 1'b1;
                    end
                end
            end
            ALTO: begin
                if (fall) begin
                    h_d     = cnt_q;
                    state_d = BAJO;
                end else if (at_max) begin
                    tout_hi    = 1'b1;
                    state_d    = ESPERA;
                    seen_low_d = 1'b0;
                    reported_d = 1'b1;
                end
            end
            BAJO: begin
                if (rise) begin
                    capture = 1'b1;
                    state_d = ALTO;
                end else if (at_max) begin
                    tout_lo    = 1'b1;
                    state_d    = ESPERA;
                    seen_low_d = 1'b1;
                    reported_d = 1'b1;
                end
            end
            default: begin
                state_d    = ESPERA;
                seen_low_d = 1'b0;
            end
        endcase
    end

    // Output logic: restoring divider of (h << R) / p and report updates.
    // The remainder starts at h because the low R numerator bits are zero, and
    // h < p keeps every partial remainder below p, so CW bits suffice.
    always_comb begin
        busy_d    = busy_q;
        div_cnt_d = div_cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dh_d      = dh_q;
        dp_d      = dp_q;
        rem_sh    = {rem_q, 1'b0};
        alto_d    = alto_q;
        periodo_d = periodo_q;
        duty_d    = duty_q;
        stuck_d   = stuck_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        if (tout_hi || tout_lo) begin
            // a timeout aborts any division in flight
            busy_d    = 1'b0;
            alto_d    = tout_hi ? CNT_MAX : '0;
            periodo_d = CNT_MAX;
            duty_d    = tout_hi ? DUTY_MAX : '0;
            stuck_d   = 1'b1;
            valid_d   = 1'b1;
        end else begin
            if (busy_q) begin
                if (div_cnt_q == '0) begin
                    alto_d    = dh_q;
                    periodo_d = dp_q;
                    duty_d    = quo_q;
                    stuck_d   = 1'b0;
                    valid_d   = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    if (rem_sh >= {1'b0, dp_q}) begin
                        rem_d = rem_sh[CW-1:0] - dp_q;
                        quo_d = {quo_q[R-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[CW-1:0];
                        quo_d = {quo_q[R-2:0], 1'b0};
                    end
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            if (capture) begin
                if (busy_q) begin
                    overrun_d = 1'b1;
                end else begin
                    dh_d      = h_q;
                    dp_d      = cnt_q;
                    rem_d     = h_q;
                    quo_d     = '0;
                    div_cnt_d = DIV_STEPS;
                    busy_d    = 1'b1;
                end
            end
        end
    end

    // Divider and report registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            div_cnt_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dh_q      <= '0;
            dp_q      <= '0;
            alto_q    <= '0;
            periodo_q <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            div_cnt_q <= div_cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dh_q      <= dh_d;
            dp_q      <= dp_d;
            alto_q    <= alto_d;
            periodo_q <= periodo_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.alto    = alto_q;
    assign bus.periodo = periodo_q;
    assign bus.duty    = duty_q;
    assign bus.valid   = valid_q;
    assign bus.stuck   = stuck_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_pwm_medidor.sv
// tb_pwm_medidor: drives PWM trains (directed and random) into pwm_medidor and
// compares every report against a pulse-level model of the measurement rules.
module tb_pwm_medidor;
    localparam int R    = 6;
    localparam int CW   = 8;
    localparam int TMAX = (1 << CW) - 1;
    localparam int DMAX = (1 << R) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    pwm_medidor_if #(.R(R), .CW(CW)) bus ();

    pwm_medidor #(.R(R), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int alto;
        int periodo;
        int duty;
        int stuck;
        int cyc;
    } rep_t;

    rep_t exp_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   ovr_seen = 0;
    int   ovr_exp  = 0;
    bit   have_prev = 1'b0;
    int   prev_h = 0;
    int   prev_l = 0;
    int   last_acc = -1000;
    bit   prev_valid = 1'b0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void expect_rep(input int a, input int p, input int d, input int s, input int c);
        rep_t e;
        e.alto    = a;
        e.periodo = p;
        e.duty    = d;
        e.stuck   = s;
        e.cyc     = c;
        exp_q.push_back(e);
    endfunction

    // Hold the line at v for n cycles (called just after a rising clock edge).
    task automatic hold(input logic v, input int n);
        bus.pwm_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One pulse: high for h cycles then low for l cycles.
    // Model: a rise following a complete pulse reports that pulse, R+4 cycles
    // after the pin edge (3 synchroniser/edge cycles + R+1 divider cycles),
    // unless a division started within the last R+1 cycles (overrun).
    // A high or low phase of 260+ cycles saturates the 8-bit counter.
    task automatic pulse(input int h, input int l);
        int rc;
        rc = cyc;
        if (have_prev) begin
            if (rc - last_acc <= R + 1) begin
                ovr_exp++;
            end else begin
                expect_rep(prev_h, prev_h + prev_l, (prev_h << R) / (prev_h + prev_l), 0, rc + R + 4);
                last_acc = rc;
            end
        end
        if (h >= 260) begin
            expect_rep(TMAX, TMAX, DMAX, 1, -1);
            have_prev = 1'b0;
            last_acc  = -1000;
        end else if (l >= 260) begin
            expect_rep(0, TMAX, 0, 1, -1);
            have_prev = 1'b0;
            last_acc  = -1000;
        end else begin
            have_prev = 1'b1;
            prev_h    = h;
            prev_l    = l;
        end
        hold(1'b1, h);
        hold(1'b0, l);
    endtask

    // Report monitor, sampled on the falling edge.
    always @(negedge clk) begin
        rep_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.valid) begin
                chk("valid_gap", prev_valid, 0);
                chk("report_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("alto", bus.alto, e.alto);
                    chk("periodo", bus.periodo, e.periodo);
                    chk("duty", bus.duty, e.duty);
                    chk("stuck", bus.stuck, e.stuck);
                    if (e.cyc >= 0) chk("latency", cyc, e.cyc);
                end
            end
            if (bus.overrun) ovr_seen++;
            prev_valid = bus.valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pwm_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alto", bus.alto, 0);
        chk("rst_periodo", bus.periodo, 0);
        chk("rst_duty", bus.duty, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_stuck", bus.stuck, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b0;

        // line held low: one stuck report, then a 10/22 train
        expect_rep(0, TMAX, 0, 1, -1);
        hold(1'b0, 300);
        repeat (3) pulse(10, 22);
        pulse(10, 300);

        // fixed 32/64
        repeat (6) pulse(32, 32);
        pulse(32, 300);

        // ciclo 16 then 48
        repeat (4) pulse(16, 48);
        repeat (4) pulse(48, 16);
        pulse(48, 300);

        // random pulse widths
        for (int i = 0; i < 24; i++) begin
            pulse(int'($urandom_range(4, 60)), int'($urandom_range(4, 60)));
        end
        pulse(int'($urandom_range(4, 60)), 300);

        // 4-cycle periods: captures faster than the divider
        repeat (12) pulse(2, 2);
        pulse(2, 300);

        // line stuck high in mid-measurement, then recovery
        pulse(20, 20);
        pulse(300, 20);
        repeat (2) pulse(12, 20);
        pulse(12, 300);

        // reset during a high phase, released with the pin high
        bus.pwm_in = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_alto", bus.alto, 0);
        chk("midrst_periodo", bus.periodo, 0);
        chk("midrst_duty", bus.duty, 0);
        chk("midrst_stuck", bus.stuck, 0);
        chk("midrst_valid", bus.valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        have_prev = 1'b0;
        last_acc  = -1000;
        hold(1'b1, 10);
        hold(1'b0, 20);
        repeat (3) pulse(30, 30);
        pulse(30, 300);

        // reset with the line held high
        rst = 1'b1;
        bus.pwm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        have_prev = 1'b0;
        last_acc  = -1000;
        expect_rep(TMAX, TMAX, DMAX, 1, -1);
        hold(1'b1, 300);
        hold(1'b0, 20);
        repeat (3) pulse(20, 44);
        pulse(20, 300);

        repeat (20) @(posedge clk);
        #1;
        chk("pending_reports", exp_q.size(), 0);
        chk("overrun_count", ovr_seen, ovr_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
